// File: rtl/conv_stream.sv
// Streaming KxK FP16 convolution: line buffers feed a KxK window, products reduce
// through a registered adder tree, then bias and optional ReLU; valid/ready on all streams.
module conv_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  k_valid,
    input  logic [DATA_WIDTH-1:0] k_data,
    output logic                  k_ready,
    input  logic                  relu_en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int K  = KERNEL_SIZE;
    localparam int N  = K * K;
    localparam int L  = $clog2(N);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int KW = $clog2(N + 1);

    localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N);

    // FP16 multiply: subnormal inputs/results flush to zero, round to nearest even.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        sg;
        logic [21:0] p;
        logic [10:0] fr;
        logic        g;
        logic        st;
        logic [11:0] rm;
        logic [15:0] r;
        int          e;
        sg = a[15] ^ b[15];
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) begin
            r = {sg, 5'h1f, 10'h000};
        end else if (a[14:10] == 5'h00 || b[14:10] == 5'h00) begin
            r = {sg, 15'h0000};
        end else begin
            p = {11'h000, 1'b1, a[9:0]} * {11'h000, 1'b1, b[9:0]};
            e = int'(a[14:10]) + int'(b[14:10]) - 15;
            if (p[21]) begin
                fr = p[21:11];
                g  = p[10];
                st = |p[9:0];
                e  = e + 1;
            end else begin
                fr = p[20:10];
                g  = p[9];
                st = |p[8:0];
            end
            rm = {1'b0, fr} + {11'h000, g & (st | fr[0])};
            if (rm[11]) begin
                rm = rm >> 1;
                e  = e + 1;
            end
            if (e >= 31)     r = {sg, 5'h1f, 10'h000};
            else if (e <= 0) r = {sg, 15'h0000};
            else             r = {sg, 5'(e), rm[9:0]};
        end
        return r;
    endfunction

    // FP16 add: operands ordered by magnitude, 3 guard bits with sticky, RNE.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        logic [13:0] mx;
        logic [13:0] my;
        logic [14:0] sm;
        logic [11:0] rm;
        logic        sticky;
        int unsigned sh;
        int          e;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        r = x;
        if (x[14:10] == 5'h1f) begin
            r = x;
        end else if (y[14:10] == 5'h00) begin
            r = (x[14:10] == 5'h00) ? {x[15] & y[15], 15'h0000} : x;
        end else begin
            mx     = {1'b1, x[9:0], 3'b000};
            my     = {1'b1, y[9:0], 3'b000};
            sh     = 32'(x[14:10] - y[14:10]);
            e      = int'(x[14:10]);
            sticky = 1'b0;
            for (int unsigned i = 0; i < 14; i++) begin
                if (i < sh) begin
                    sticky = sticky | my[0];
                    my     = my >> 1;
                end
            end
            my[0] = my[0] | sticky;
            if (x[15] == y[15]) begin
                sm = {1'b0, mx} + {1'b0, my};
                if (sm[14]) begin
                    sm = {1'b0, sm[14:2], sm[1] | sm[0]};
                    e  = e + 1;
                end
            end else begin
                sm = {1'b0, mx} - {1'b0, my};
                for (int unsigned i = 0; i < 13; i++) begin
                    if (!sm[13] && sm != 15'h0000) begin
                        sm = sm << 1;
                        e  = e - 1;
                    end
                end
            end
            if (sm == 15'h0000) begin
                r = 16'h0000;
            end else begin
                rm = {1'b0, sm[13:3]} + {11'h000, sm[2] & (sm[1] | sm[0] | sm[3])};
                if (rm[11]) begin
                    rm = rm >> 1;
                    e  = e + 1;
                end
                if (e >= 31)     r = {x[15], 5'h1f, 10'h000};
                else if (e <= 0) r = {x[15], 15'h0000};
                else             r = {x[15], 5'(e), rm[9:0]};
            end
        end
        return r;
    endfunction

    function automatic int unsigned lvl_n(input int unsigned l);
        int unsigned n;
        n = N;
        for (int unsigned j = 0; j < l; j++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v < N) ? v : N - 1;
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [KW-1:0] kcnt;
    logic [15:0]   weight [K][K];
    logic [15:0]   bias;
    logic [15:0]   lb [K-1][IMG_WIDTH];
    logic [15:0]   win [K][K];
    logic          w_valid;
    logic          w_last;
    logic [15:0]   lvl [L+1][N];
    logic [L:0]    lvl_v;
    logic [L:0]    lvl_l;
    logic [15:0]   bsum;
    logic          stall;
    logic          idle;
    logic          k_accept;
    logic          accept;
    logic          win_ok;
    logic          frame_end;

    always_comb begin
        stall     = out_valid && !out_ready;
        idle      = (col == '0) && (row == '0) && !w_valid && (lvl_v == '0) && !out_valid;
        k_ready   = idle;
        k_accept  = k_valid && idle;
        in_ready  = !stall && (kcnt == '0) && !k_accept;
        accept    = in_valid && in_ready;
        win_ok    = (col >= COL_K1) && (row >= ROW_K1);
        frame_end = (col == COL_LAST) && (row == ROW_LAST);
        bsum      = fp16_add(lvl[L][0], bias);
    end

    // Control state and output register; everything here clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            kcnt      <= '0;
            bias      <= '0;
            w_valid   <= 1'b0;
            w_last    <= 1'b0;
            lvl_v     <= '0;
            lvl_l     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < K; c++)
                    weight[r][c] <= '0;
        end else begin
            if (k_accept) begin
                kcnt <= (kcnt == K_LAST) ? '0 : kcnt + 1'b1;
                for (int unsigned r = 0; r < K; r++)
                    for (int unsigned c = 0; c < K; c++)
                        if (kcnt == KW'(r * K + c)) weight[r][c] <= k_data;
                if (kcnt == K_LAST) bias <= k_data;
            end
            if (accept) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
                if (col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end
            if (!stall) begin
                w_valid   <= accept && win_ok;
                w_last    <= accept && frame_end;
                lvl_v     <= {lvl_v[L-1:0], w_valid};
                lvl_l     <= {lvl_l[L-1:0], w_last};
                out_valid <= lvl_v[L];
                out_last  <= lvl_l[L];
                out_data  <= (relu_en && bsum[15]) ? '0 : bsum;
            end
        end
    end

    // Datapath: window/line buffers move only on accepted pixels, pipeline on !stall.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c + 1 < K; c++)
                    win[r][c] <= win[r][c+1];
            for (int unsigned r = 0; r + 1 < K; r++)
                win[r][K-1] <= lb[K-2-r][col];
            win[K-1][K-1] <= in_data;
            lb[0][col] <= in_data;
            for (int unsigned j = 1; j + 1 < K; j++)
                lb[j][col] <= lb[j-1][col];
        end
        if (!stall) begin
            for (int unsigned r = 0; r < K; r++)
                for (int unsigned c = 0; c < K; c++)
                    lvl[0][r*K+c] <= fp16_mul(win[r][c], weight[r][c]);
            for (int unsigned l = 1; l <= L; l++) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < lvl_n(l)) begin
                        if (2 * i + 1 < lvl_n(l - 1))
                            lvl[l][i] <= fp16_add(lvl[l-1][sat(2*i)], lvl[l-1][sat(2*i+1)]);
                        else
                            lvl[l][i] <= lvl[l-1][sat(2*i)];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream (K=3, 5x5 frames): stimulus pushes expected
// results, a negedge monitor pops and compares on each accepted output.
module tb_conv_stream;

    localparam int K = 3;
    localparam int W = 5;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        k_valid = 1'b0;
    logic [15:0] k_data = '0;
    logic        k_ready;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    conv_stream #(.DATA_WIDTH(16), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
        .relu_en(relu_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    int          nchk = 0;
    int          npass = 0;
    int          nout = 0;
    int unsigned cyc = 0;
    int unsigned first_cyc = 0;
    bit          got_first = 1'b0;
    logic [16:0] expq [$];
    logic [16:0] mon_exp;
    logic [15:0] kw [10];
    logic [15:0] px [25];
    int unsigned acc_cyc [25];

    // FP16 encodings of the integers 0..24
    logic [15:0] ftab [25] = '{
        16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700,
        16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80,
        16'h4C00, 16'h4C40, 16'h4C80, 16'h4CC0, 16'h4D00, 16'h4D40, 16'h4D80, 16'h4DC0,
        16'h4E00};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    function automatic void tmo(input string name);
        nchk++;
        $display("FAIL %s: timed out, got no handshake, expected one", name);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (!got_first) begin
                got_first = 1'b1;
                first_cyc = cyc;
            end
            nout++;
            if (expq.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_output: got %h last %b, expected none", out_data, out_last);
            end else begin
                mon_exp = expq.pop_front();
                chk("out_last_data", {15'h0, out_last, out_data}, {15'h0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_kernel(input logic [15:0] w, input logic [15:0] b, input bit centre_only);
        for (int i = 0; i < 9; i++) kw[i] = centre_only ? ((i == 4) ? 16'h3C00 : 16'h0000) : w;
        kw[9] = b;
    endtask

    task automatic load_kernel(input bit sim_chk);
        bit ok;
        int n;
        for (int i = 0; i < 10; i++) begin
            k_valid = 1'b1;
            k_data  = kw[i];
            n = 0;
            do begin
                @(negedge clk);
                ok = k_ready;
                if (sim_chk && (i == 0 || i == 9)) chk("in_ready_during_kload", {31'h0, in_ready}, 32'h0);
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 200);
            if (!ok) tmo("k_ready_wait");
        end
        k_valid = 1'b0;
    endtask

    task automatic push_n(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) expq.push_back({(i == n - 1), v});
    endtask

    task automatic send_frame(input int npix, input bit kv_test);
        bit ok;
        int n;
        for (int p = 0; p < npix; p++) begin
            in_valid = 1'b1;
            in_data  = px[p];
            if (kv_test && p == 3) begin
                k_valid = 1'b1;
                k_data  = 16'h4000;
            end
            if (kv_test && p == 5) chk("k_ready_mid_frame", {31'h0, k_ready}, 32'h0);
            if (kv_test && p == 10) k_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 200);
            if (!ok) tmo("in_ready_wait");
            acc_cyc[p] = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (expq.size() != 0) tmo("drain_outputs");
        repeat (10) tick();
    endtask

    task automatic stall_window();
        int n;
        logic [16:0] head;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) tmo("first_output_before_stall");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("in_ready_stalled", {31'h0, in_ready}, 32'h0);
            chk("out_valid_stalled", {31'h0, out_valid}, 32'h1);
            if (expq.size() == 0) begin
                tmo("stall_expect_queue");
            end else begin
                head = expq[0];
                chk("out_data_held", {16'h0, out_data}, {16'h0, head[15:0]});
            end
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_k_ready", {31'h0, k_ready}, 32'h1);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {16'h0, out_data}, 32'h0);
        chk("rst_out_last", {31'h0, out_last}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // all-ones kernel, frame of 1.0; k_valid poked mid-frame must be ignored
        set_kernel(16'h3C00, 16'h0000, 1'b0);
        load_kernel(1'b0);
        for (int i = 0; i < 25; i++) px[i] = 16'h3C00;
        push_n(16'h4880, 9);
        got_first = 1'b0;
        nout = 0;
        send_frame(25, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("latency_pix12", first_cyc - acc_cyc[12], 32'd6);
        chk("count_ones", nout, 32'd9);

        // centre tap picks out pixel index values
        set_kernel(16'h0000, 16'h0000, 1'b1);
        load_kernel(1'b0);
        for (int i = 0; i < 25; i++) px[i] = ftab[i];
        for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++)
                expq.push_back({(r == 3 && c == 3), ftab[r*5+c]});
        nout = 0;
        send_frame(25, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("count_position", nout, 32'd9);

        // negative weights with and without ReLU, then negative bias
        set_kernel(16'hBC00, 16'h0000, 1'b0);
        load_kernel(1'b0);
        for (int i = 0; i < 25; i++) px[i] = 16'h3C00;
        push_n(16'hC880, 9);
        send_frame(25, 1'b0);
        in_valid = 1'b0;
        drain();
        relu_en = 1'b1;
        push_n(16'h0000, 9);
        send_frame(25, 1'b0);
        in_valid = 1'b0;
        drain();
        relu_en = 1'b0;
        set_kernel(16'h3C00, 16'hBC00, 1'b0);
        load_kernel(1'b0);
        push_n(16'h4800, 9);
        send_frame(25, 1'b0);
        in_valid = 1'b0;
        drain();

        // backpressure with distinct output values
        set_kernel(16'h0000, 16'h0000, 1'b1);
        load_kernel(1'b0);
        for (int i = 0; i < 25; i++) px[i] = ftab[i];
        for (int r = 1; r <= 3; r++)
            for (int c = 1; c <= 3; c++)
                expq.push_back({(r == 3 && c == 3), ftab[r*5+c]});
        nout = 0;
        fork
            send_frame(25, 1'b0);
            stall_window();
        join
        in_valid = 1'b0;
        drain();
        chk("count_backpressure", nout, 32'd9);

        // back-to-back frames; pixel held valid while the kernel loads
        set_kernel(16'h3C00, 16'h0000, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        load_kernel(1'b1);
        for (int i = 0; i < 25; i++) px[i] = 16'h3C00;
        push_n(16'h4880, 9);
        push_n(16'h4C80, 9);
        nout = 0;
        send_frame(25, 1'b0);
        first_cyc = acc_cyc[24];
        for (int i = 0; i < 25; i++) px[i] = 16'h4000;
        send_frame(25, 1'b0);
        chk("frame_boundary_gap", acc_cyc[0] - first_cyc, 32'd1);
        in_valid = 1'b0;
        drain();
        chk("count_b2b", nout, 32'd18);

        // reset at pixel 15 drops in-flight results and clears weights
        set_kernel(16'h3C00, 16'h0000, 1'b0);
        load_kernel(1'b0);
        for (int i = 0; i < 25; i++) px[i] = 16'h3C00;
        nout = 0;
        send_frame(15, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (12) tick();
        chk("count_after_rst", nout, 32'd0);
        chk("k_ready_after_rst", {31'h0, k_ready}, 32'h1);
        chk("out_valid_after_rst", {31'h0, out_valid}, 32'h0);
        push_n(16'h0000, 9);
        send_frame(25, 1'b0);
        in_valid = 1'b0;
        drain();
        chk("count_zero_weights", nout, 32'd9);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
